// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART control slice: arbiter state encoding,
// byte width and the default requester count.
package uart_ctrl_pkg;

  localparam int UART_BYTE_W   = 8;
  localparam int N_REQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_START     = 2'd1,
    ARB_WAIT_BUSY = 2'd2,
    ARB_WAIT_DONE = 2'd3
  } tx_arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational one-hot round-robin selector. The search starts at the
// index just after last_winner and wraps; pick is zero when no req is set.
module rr_picker
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [N_REQ-1:0] pick
);

  logic             found_s;
  logic [IDX_W-1:0] idx_s;

  // Walk the requesters in priority order; the first one set wins.
  always_comb begin
    pick    = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx_s        = IDX_W'((int'(last_winner) + i) % N_REQ);
      pick[idx_s]  = req[idx_s] & ~found_s;
      found_s      = found_s | req[idx_s];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 byte transmitter between N_REQ
// requesters, with optional packet lock and a busy-rise timeout fault.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEFAULT,
  parameter int BUSY_TO = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             ack,
  output logic [N_REQ-1:0]             grant,
  output logic                         tx_start,
  output logic [UART_BYTE_W-1:0]       tx_data,
  input  logic                         tx_busy,
  output logic                         tx_err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  tx_arb_state_t          state_q, state_d;
  logic [N_REQ-1:0]       grant_q, grant_d;
  logic [N_REQ-1:0]       ack_q, ack_d;
  logic [IDX_W-1:0]       winner_q, winner_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic                   lock_q, lock_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   tx_err_q, tx_err_d;

  logic [N_REQ-1:0]       pick_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic [UART_BYTE_W-1:0] pick_data_s;
  logic [UART_BYTE_W-1:0] win_data_s;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req         (req),
    .last_winner (last_q),
    .pick        (pick_s)
  );

  // One-hot to index/byte muxes for the fresh pick and the current owner.
  always_comb begin
    pick_idx_s  = '0;
    pick_data_s = '0;
    win_data_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pick_idx_s  = pick_idx_s  | ({IDX_W{pick_s[i]}} & IDX_W'(i));
      pick_data_s = pick_data_s | ({UART_BYTE_W{pick_s[i]}} & req_data[i*UART_BYTE_W +: UART_BYTE_W]);
      win_data_s  = win_data_s  | ({UART_BYTE_W{grant_q[i]}} & req_data[i*UART_BYTE_W +: UART_BYTE_W]);
    end
  end

  // Next-state logic; tx_start and ack are raised on entry to START so
  // they are registered yet high exactly during the START cycle.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ack_d      = '0;
    winner_d   = winner_q;
    last_d     = last_q;
    lock_d     = lock_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    tx_err_d   = tx_err_q;
    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          grant_d    = pick_s;
          winner_d   = pick_idx_s;
          tx_data_d  = pick_data_s;
          tx_start_d = 1'b1;
          ack_d      = pick_s;
          state_d    = ARB_START;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_START: begin
        lock_d  = ~req_last[winner_q];
        cnt_d   = 8'd1;
        state_d = ARB_WAIT_BUSY;
      end
      ARB_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ARB_WAIT_DONE;
        end else if (cnt_q == 8'(BUSY_TO - 1)) begin
          // cnt_q counts cycles since START, so the fault lands BUSY_TO after it.
          tx_err_d = 1'b1;
          lock_d   = 1'b0;
          grant_d  = '0;
          state_d  = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ARB_WAIT_DONE: begin
        if (tx_busy) begin
          state_d = ARB_WAIT_DONE;
        end else if (!lock_q) begin
          last_d  = winner_q;
          grant_d = '0;
          state_d = ARB_IDLE;
        end else if (req[winner_q]) begin
          tx_data_d  = win_data_s;
          tx_start_d = 1'b1;
          ack_d      = grant_q;
          state_d    = ARB_START;
        end else begin
          state_d = ARB_WAIT_DONE;
        end
      end
      default: begin
        grant_d = '0;
        lock_d  = 1'b0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      ack_q      <= '0;
      winner_q   <= '0;
      last_q     <= IDX_W'(N_REQ - 1);
      lock_q     <= 1'b0;
      cnt_q      <= 8'd0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      winner_q   <= winner_d;
      last_q     <= last_d;
      lock_q     <= lock_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      tx_err_q   <= tx_err_d;
    end
  end

  assign ack      = ack_q;
  assign grant    = grant_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign tx_err   = tx_err_q;

endmodule
